scoot_world: RTL and testbench

Synthesizable grid-world engine: the environment side of the scoot-bot sensor/motor interface. It holds a WIDTH×HEIGHT pellet map and the robot position, turns the robot's four motor requests into a wrapped position update, and collects pellets on arrival. It drives the four neighbour-light sensor lines back to the robot and keeps a score. It replaces the behavioural simulator loop with clocked hardware, so a scoot-bot can be evaluated closed-loop in RTL.

---
 rtl/scoot_world.sv | 138 +++++++++++++
 tb/tb_scoot_world.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scoot_world.sv
// Grid-world environment for a scoot-bot: pellet map, wrapped robot motion,
// pellet collection, neighbour-light sensors and an episode score.
module scoot_world #(
  parameter int                WIDTH       = 10,
  parameter int                HEIGHT      = 10,
  parameter logic [HEIGHT-1:0] COL_PATTERN = 10'b0010101001,
  parameter int                NUM_STEPS   = 64,
  parameter int                SCORE_W     = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       step,
  input  logic                       mUp,
  input  logic                       mRight,
  input  logic                       mDown,
  input  logic                       mLeft,
  output logic                       lUp,
  output logic                       lRight,
  output logic                       lDown,
  output logic                       lLeft,
  output logic [$clog2(WIDTH)-1:0]   posX,
  output logic [$clog2(HEIGHT)-1:0]  posY,
  output logic [SCORE_W-1:0]         score,
  output logic                       picked,
  output logic                       ready,
  output logic                       done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(NUM_STEPS + 1);

  localparam logic [XW-1:0] X_MAX      = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX      = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_MID      = XW'(WIDTH / 2);
  localparam logic [YW-1:0] Y_MID      = YW'(HEIGHT / 2);
  localparam logic [CW-1:0] STEP_LIMIT = CW'(NUM_STEPS);

  typedef enum logic [2:0] {IDLE, LOAD, COLLECT, RUN, DONE} worldState;

  worldState         state, nextState;
  logic              doLoad, doCollect, doMove;
  logic [HEIGHT-1:0] pelletMap [WIDTH];
  logic [CW-1:0]     stepCount;
  logic [XW-1:0]     xPlus, xMinus, nextX;
  logic [YW-1:0]     yPlus, yMinus, nextY;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    doLoad    = 1'b0;
    doCollect = 1'b0;
    doMove    = 1'b0;
    unique case (state)
      IDLE:    if (start) nextState = LOAD;
      LOAD: begin
        doLoad    = 1'b1;
        nextState = COLLECT;
      end
      COLLECT: begin
        doCollect = 1'b1;
        nextState = (stepCount == STEP_LIMIT) ? DONE : RUN;
      end
      RUN: if (step) begin
        doMove    = 1'b1;
        nextState = COLLECT;
      end
      DONE:    if (start) nextState = LOAD;
      default: nextState = IDLE;
    endcase
  end

  assign ready = (state == RUN);
  assign done  = (state == DONE);

  // Wrapped neighbour coordinates, shared by motion and the light sensors.
  assign xPlus  = (posX == X_MAX) ? '0    : posX + 1'b1;
  assign xMinus = (posX == '0)    ? X_MAX : posX - 1'b1;
  assign yPlus  = (posY == Y_MAX) ? '0    : posY + 1'b1;
  assign yMinus = (posY == '0)    ? Y_MAX : posY - 1'b1;

  // Opposing motor requests cancel on each axis.
  always_comb begin
    nextX = posX;
    nextY = posY;
    if (mRight && !mLeft)      nextX = xPlus;
    else if (mLeft && !mRight) nextX = xMinus;
    if (mUp && !mDown)         nextY = yPlus;
    else if (mDown && !mUp)    nextY = yMinus;
  end

  // NOTE: the pellet map is cleared on reset because the sensors must read 0
  // from reset onward; it is a small register array, not a RAM macro.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) pelletMap[i] <= '0;
      posX      <= '0;
      posY      <= '0;
      score     <= '0;
      stepCount <= '0;
      picked    <= 1'b0;
    end else begin
      picked <= 1'b0;
      if (doLoad) begin
        for (int i = 0; i < WIDTH; i++) pelletMap[i] <= COL_PATTERN;
        posX      <= X_MID;
        posY      <= Y_MID;
        score     <= '0;
        stepCount <= '0;
      end
      if (doCollect && pelletMap[posX][posY]) begin
        pelletMap[posX][posY] <= 1'b0;
        picked                <= 1'b1;
        if (score != '1) score <= score + 1'b1;
      end
      if (doMove) begin
        posX      <= nextX;
        posY      <= nextY;
        stepCount <= stepCount + 1'b1;
      end
    end
  end

  assign lUp    = pelletMap[posX][yPlus];
  assign lDown  = pelletMap[posX][yMinus];
  assign lRight = pelletMap[xPlus][posY];
  assign lLeft  = pelletMap[xMinus][posY];

endmodule

// File: tb/tb_scoot_world.sv
// Directed and randomized bench for scoot_world, checked against a grid model
// built from plain modular arithmetic; a second instance covers episode end.
module tb_scoot_world;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int NS = 64;

  logic       clock = 1'b0;
  logic       reset_n, start, step, start2, step2;
  logic       mUp, mRight, mDown, mLeft;
  logic       lUp, lRight, lDown, lLeft;
  logic [3:0] posX, posY;
  logic [7:0] score;
  logic       picked, ready, done;
  logic       sUp, sRight, sDown, sLeft;
  logic [3:0] sPosX, sPosY;
  logic [7:0] sScore;
  logic       sPicked, sReady, sDone;

  int total = 0;
  int bad   = 0;

  scoot_world dut (
    .clock(clock), .reset_n(reset_n), .start(start), .step(step),
    .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft),
    .lUp(lUp), .lRight(lRight), .lDown(lDown), .lLeft(lLeft),
    .posX(posX), .posY(posY), .score(score), .picked(picked),
    .ready(ready), .done(done)
  );

  scoot_world #(.NUM_STEPS(3)) dutShort (
    .clock(clock), .reset_n(reset_n), .start(start2), .step(step2),
    .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft),
    .lUp(sUp), .lRight(sRight), .lDown(sDown), .lLeft(sLeft),
    .posX(sPosX), .posY(sPosY), .score(sScore), .picked(sPicked),
    .ready(sReady), .done(sDone)
  );

  always #5 clock = ~clock;

  // Reference model of the main instance.
  logic [H-1:0] colPattern = 10'b0010101001;
  bit           mMap [W][H];
  int           mx, my, mScore, mSteps;
  bit           mPicked;

  function automatic void modelLoad();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) mMap[x][y] = colPattern[y];
    mx = W / 2;
    my = H / 2;
    mScore = 0;
    mSteps = 0;
  endfunction

  function automatic void modelCollect();
    mPicked = mMap[mx][my];
    if (mPicked) begin
      mMap[mx][my] = 1'b0;
      if (mScore < 255) mScore++;
    end
  endfunction

  function automatic void modelMove(input bit u, input bit r, input bit d, input bit l);
    int dx, dy;
    dx = int'(r) - int'(l);
    dy = int'(u) - int'(d);
    mx = (mx + dx + W) % W;
    my = (my + dy + H) % H;
    mSteps++;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkPos(input string tag);
    check({tag, ".x"}, 32'(posX), mx);
    check({tag, ".y"}, 32'(posY), my);
  endtask

  task automatic checkAfterCollect(input string tag);
    checkPos(tag);
    check({tag, ".picked"}, 32'(picked), 32'(mPicked));
    check({tag, ".score"}, 32'(score), mScore);
    check({tag, ".ready"}, 32'(ready), 32'(mSteps < NS));
    check({tag, ".done"}, 32'(done), 32'(mSteps == NS));
    check({tag, ".lights"}, 32'({lUp, lRight, lDown, lLeft}),
          32'({mMap[mx][(my + 1) % H], mMap[(mx + 1) % W][my],
               mMap[mx][(my + H - 1) % H], mMap[(mx + W - 1) % W][my]}));
  endtask

  task automatic doStart(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".loadReady"}, 32'(ready), 32'd0);
    tick();
    modelLoad();
    checkPos({tag, ".collect"});
    check({tag, ".collectPicked"}, 32'(picked), 32'd0);
    tick();
    modelCollect();
    checkAfterCollect(tag);
  endtask

  task automatic doStep(input string tag, input bit u, input bit r, input bit d, input bit l);
    check({tag, ".readyBefore"}, 32'(ready), 32'd1);
    {mUp, mRight, mDown, mLeft} = {u, r, d, l};
    step = 1'b1;
    tick();
    step = 1'b0;
    modelMove(u, r, d, l);
    checkPos({tag, ".move"});
    check({tag, ".moveReady"}, 32'(ready), 32'd0);
    check({tag, ".movePicked"}, 32'(picked), 32'd0);
    tick();
    modelCollect();
    checkAfterCollect(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    {start, step, start2, step2} = 4'b1111;
    {mUp, mRight, mDown, mLeft} = 4'b1111;
    tick();
    tick();
    check("reset.pos", 32'({posX, posY}), 32'd0);
    check("reset.score", 32'(score), 32'd0);
    check("reset.flags", 32'({picked, ready, done}), 32'd0);
    check("reset.lights", 32'({lUp, lRight, lDown, lLeft}), 32'd0);
    check("reset.short", 32'({sScore, sReady, sDone, sPicked}), 32'd0);

    reset_n = 1'b1;
    {start, step, start2, step2} = 4'b0000;
    {mUp, mRight, mDown, mLeft} = 4'b0000;
    tick();
    check("idle.hold", 32'({ready, done, picked, score}), 32'd0);

    // Episode end on a three-step instance.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    check("short.start.score", 32'(sScore), 32'd1);
    check("short.start.pos", 32'({sPosX, sPosY}), 32'h55);
    check("short.start.ready", 32'({sReady, sDone}), 32'b10);
    mRight = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step2 = 1'b1;
      tick();
      step2 = 1'b0;
      check("short.step.x", 32'(sPosX), 32'(6 + i));
      tick();
      check("short.step.score", 32'(sScore), 32'(2 + i));
      check("short.step.picked", 32'(sPicked), 32'd1);
      check("short.step.readyDone", 32'({sReady, sDone}), (i < 2) ? 32'b10 : 32'b01);
    end
    step2 = 1'b1;
    tick();
    step2 = 1'b0;
    tick();
    check("short.doneHold.pos", 32'({sPosX, sPosY}), 32'h85);
    check("short.doneHold.score", 32'(sScore), 32'd4);
    check("short.doneHold.flags", 32'({sReady, sDone, sPicked}), 32'b010);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    check("short.restart.score", 32'(sScore), 32'd1);
    check("short.restart.pos", 32'({sPosX, sPosY}), 32'h55);
    check("short.restart.lRight", 32'(sRight), 32'd1);
    check("short.restart.flags", 32'({sReady, sDone}), 32'b10);
    mRight = 1'b0;

    // Main episode: directed walk, then random steps to the end.
    doStart("start");
    check("start.lit.score", 32'(score), 32'd1);
    check("start.lit.lights", 32'({lUp, lRight, lDown, lLeft}), 32'b0101);
    doStep("right", 0, 1, 0, 0);
    check("right.lit", 32'({posX, posY, score}), 32'h65_02);
    doStep("left1", 0, 0, 0, 1);
    check("left1.lit.score", 32'(score), 32'd2);
    doStep("left2", 0, 0, 0, 1);
    check("left2.lit", 32'({posX, posY, score}), 32'h45_03);
    doStep("backRight", 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) doStep("down", 0, 0, 1, 0);
    check("down5.lit", 32'({posX, posY, score}), 32'h50_05);
    doStep("downWrap", 0, 0, 1, 0);
    check("downWrap.lit.y", 32'(posY), 32'd9);
    doStep("cancelY", 1, 0, 1, 0);
    doStep("cancelX", 0, 1, 0, 1);
    doStep("cancelAll", 1, 1, 1, 1);
    check("cancel.lit.pos", 32'({posX, posY}), 32'h59);

    while (mSteps < NS) begin
      {mUp, mRight, mDown, mLeft} = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) tick();
      doStep("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("end.doneReady", 32'({done, ready}), 32'b10);

    {mUp, mRight, mDown, mLeft} = 4'b0100;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    mPicked = 1'b0;
    checkAfterCollect("doneStepIgnored");

    doStart("restart");

    // Reset dropped while COLLECT is about to pick the pellet at (6,5).
    {mUp, mRight, mDown, mLeft} = 4'b0100;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("midReset.inCollect", 32'({posX, posY, ready}), 32'h65_0 >> 3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midReset.pos", 32'({posX, posY}), 32'd0);
    check("midReset.score", 32'(score), 32'd0);
    check("midReset.flags", 32'({picked, ready, done}), 32'd0);
    check("midReset.lights", 32'({lUp, lRight, lDown, lLeft}), 32'd0);
    tick();
    check("midReset.idle", 32'({picked, ready, done, score}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
